pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 20 ++
 rtl/pipe_stage_reg_if.sv | 9 +
 rtl/pipe_stage_reg_slot.sv | 29 ++
 rtl/pipe_stage_reg.sv | 65 ++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: stage state encoding, ID/EX control bit indices and per-stage default widths.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} stage_state_e;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUOP_HI = 4;
  localparam int CTRL_ALUOP_LO = 2;
  localparam int CTRL_REGDST   = 1;
  localparam int CTRL_ALUSRC   = 0;
  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 122;
  localparam int ID_EX_CTRL_W  = 9;
  localparam int EX_MEM_DATA_W = 69;
  localparam int EX_MEM_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: one valid/ready beat channel carrying payload and control word.
interface pipe_stage_reg_if #(parameter int DATA_W = 122, parameter int CTRL_W = 9);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  modport master (output valid, data, ctrl, input ready);
  modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_stage_slot: one beat register (valid + data + ctrl) with load and clear; clear zeroes ctrl, keeps data.
module pipe_stage_slot #(
  parameter int DATA_W = 1,
  parameter int CTRL_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);
  always_ff @(posedge clk)
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (ld) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with 2-entry skid and flush-to-bubble.
// Defining PIPE_STAGE_PERF_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);
  stage_state_e      state;
  logic              in_fire, out_fire;
  logic              head_ld, head_clr, skid_ld, skid_clr;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  assign up.ready = state != FULL;
  assign in_fire  = up.valid && up.ready;
  assign out_fire = dn.valid && dn.ready;
  assign head_ld  = !flush && ((state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire) ||
                               (state == FULL && out_fire));
  assign head_clr = flush || (state == ONE && out_fire && !in_fire);
  assign skid_ld  = !flush && state == ONE && in_fire && !out_fire;
  assign skid_clr = flush || (state == FULL && out_fire);
  pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk(clk), .rst_n(rst_n), .clr(head_clr), .ld(head_ld),
    .d_data(skid_valid ? skid_data : up.data), .d_ctrl(skid_valid ? skid_ctrl : up.ctrl),
    .q_valid(dn.valid), .q_data(dn.data), .q_ctrl(dn.ctrl)
  );
  pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .clr(skid_clr), .ld(skid_ld),
    .d_data(up.data), .d_ctrl(up.ctrl),
    .q_valid(skid_valid), .q_data(skid_data), .q_ctrl(skid_ctrl)
  );
  always_ff @(posedge clk)
    if (!rst_n || flush) state <= EMPTY;
    else
      case (state)
        EMPTY:   state <= in_fire ? ONE : EMPTY;
        ONE:     state <= (in_fire && !out_fire) ? FULL : (out_fire && !in_fire) ? EMPTY : ONE;
        FULL:    state <= out_fire ? ONE : FULL;
        default: state <= EMPTY;
      endcase
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (dn.valid && !dn.ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (!dn.valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus random traffic against a queue model of the stage.
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  localparam int DW = ID_EX_DATA_W;
  localparam int CW = ID_EX_CTRL_W;
  typedef struct packed {logic [DW-1:0] d; logic [CW-1:0] c;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn ();
`ifdef PIPE_STAGE_PERF_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  int m_stall, m_bubble;
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up), .dn(dn),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));
`else
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up), .dn(dn));
`endif
  beat_t q[$];
  logic [7:0] dut_log[$];
  int tests = 0, fails = 0;

  // Reference: a FIFO of at most two beats; flush empties it after any same-cycle consume.
  task automatic cycle();
    if (rst_n && dn.valid === 1'b1 && dn.ready) dut_log.push_back(dn.data[7:0]);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
`ifdef PIPE_STAGE_PERF_EN
      m_stall = 0;
      m_bubble = 0;
`endif
    end else begin
      bit of, inf;
      of  = q.size() > 0 && dn.ready;
      inf = up.valid && q.size() < 2;
`ifdef PIPE_STAGE_PERF_EN
      if (q.size() > 0 && !dn.ready && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (q.size() == 0 && m_bubble < (1 << CNT_W) - 1) m_bubble++;
`endif
      if (of) void'(q.pop_front());
      if (flush) q.delete();
      else if (inf) q.push_back('{up.data, up.ctrl});
    end
    #1;
  endtask

  task automatic drive(input bit v, input int d, input logic [CW-1:0] c);
    up.valid = v;
    up.data  = DW'(d);
    up.ctrl  = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dn.ready = 1'b0; flush = 1'b0;
    drive(1, 'h55, 9'h1FF);
    cycle(); cycle();
    drive(0, 0, '0);
    rst_n = 1'b1;
    cycle();
    tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", dn.valid); end
    tests++; if (dn.ctrl !== '0) begin fails++; $display("FAIL reset_ctrl got %h exp 0", dn.ctrl); end
    tests++; if (up.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", up.ready); end
  endtask

  task automatic test_stream();
    dn.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 9'h100 | CW'(i));
      cycle();
      tests++;
      if (dn.valid !== 1'b1 || dn.data !== DW'(i) || dn.ctrl !== (9'h100 | CW'(i))) begin
        fails++; $display("FAIL stream_%0d got v=%b d=%0h c=%h exp v=1 d=%0h c=%h", i, dn.valid, dn.data, dn.ctrl, i, 9'h100 | i);
      end
    end
    drive(0, 0, '0);
    cycle();
    tests++; if (dn.valid !== 1'b0 || dn.ctrl !== '0) begin fails++; $display("FAIL stream_drain got v=%b c=%h exp v=0 c=0", dn.valid, dn.ctrl); end
  endtask

  task automatic test_stall();
    dn.ready = 1'b0;
    dut_log.delete();
    drive(1, 'hA, 9'h10A); cycle();
    drive(1, 'hB, 9'h10B); cycle();
    drive(1, 'hC, 9'h10C); cycle(); cycle();
    tests++; if (dn.valid !== 1'b1 || dn.data !== DW'('hA) || dn.ctrl !== 9'h10A) begin fails++; $display("FAIL stall_head got v=%b d=%0h c=%h exp v=1 d=a c=10a", dn.valid, dn.data, dn.ctrl); end
    tests++; if (up.ready !== 1'b0) begin fails++; $display("FAIL stall_ready got %b exp 0", up.ready); end
    dn.ready = 1'b1;
    cycle();
    tests++; if (dn.data !== DW'('hB) || dn.ctrl !== 9'h10B) begin fails++; $display("FAIL stall_b got d=%0h c=%h exp d=b c=10b", dn.data, dn.ctrl); end
    cycle();
    tests++; if (dn.data !== DW'('hC) || dn.valid !== 1'b1) begin fails++; $display("FAIL stall_c got v=%b d=%0h exp v=1 d=c", dn.valid, dn.data); end
    drive(0, 0, '0);
    cycle();
    tests++; if (dut_log.size() != 3 || dut_log[0] != 8'hA || dut_log[1] != 8'hB || dut_log[2] != 8'hC) begin fails++; $display("FAIL stall_order got %p exp a b c", dut_log); end
    tests++; if (dn.valid !== 1'b0) begin fails++; $display("FAIL stall_empty got %b exp 0", dn.valid); end
  endtask

  task automatic test_flush_full();
    dn.ready = 1'b0;
    drive(1, 'h1, 9'h101); cycle();
    drive(1, 'h2, 9'h102); cycle();
    drive(1, 'hD, 9'h10D); flush = 1'b1; cycle();
    flush = 1'b0; drive(0, 0, '0);
    tests++; if (dn.valid !== 1'b0 || dn.ctrl !== '0 || up.ready !== 1'b1) begin fails++; $display("FAIL flush_full got v=%b c=%h r=%b exp v=0 c=0 r=1", dn.valid, dn.ctrl, up.ready); end
    drive(1, 'h3, 9'h103); cycle();
    drive(1, 'hD, 9'h10D); flush = 1'b1; cycle();
    flush = 1'b0; drive(0, 0, '0);
    dut_log.delete();
    dn.ready = 1'b1;
    cycle(); cycle(); cycle();
    tests++; if (dut_log.size() != 0 || dn.valid !== 1'b0) begin fails++; $display("FAIL flush_drop got %0d beats v=%b exp 0 beats v=0", dut_log.size(), dn.valid); end
  endtask

  task automatic test_flush_fire();
    dn.ready = 1'b0;
    drive(1, 'hE, 9'h10E); cycle();
    drive(0, 0, '0);
    dut_log.delete();
    dn.ready = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0; cycle(); cycle();
    tests++; if (dut_log.size() != 1 || dut_log[0] != 8'hE) begin fails++; $display("FAIL flush_fire got %p exp one e", dut_log); end
    tests++; if (dn.valid !== 1'b0 || up.ready !== 1'b1) begin fails++; $display("FAIL flush_fire_state got v=%b r=%b exp v=0 r=1", dn.valid, up.ready); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      logic [127:0] r;
      logic [CW-1:0] ec;
      r = {$urandom, $urandom, $urandom, $urandom};
      up.valid = $urandom_range(0, 3) != 0;
      up.data  = r[DW-1:0];
      up.ctrl  = CW'($urandom);
      dn.ready = $urandom_range(0, 2) != 0;
      flush    = $urandom_range(0, 19) == 0;
      cycle();
      ec = q.size() > 0 ? q[0].c : '0;
      tests++; if (dn.valid !== (q.size() > 0)) begin fails++; bad++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, dn.valid, q.size() > 0); end
      tests++; if (dn.ctrl !== ec) begin fails++; bad++; $display("FAIL rnd_ctrl cyc %0d got %h exp %h", i, dn.ctrl, ec); end
      tests++; if (up.ready !== (q.size() < 2)) begin fails++; bad++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, up.ready, q.size() < 2); end
      if (q.size() > 0) begin
        tests++; if (dn.data !== q[0].d) begin fails++; bad++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, dn.data, q[0].d); end
      end
`ifdef PIPE_STAGE_PERF_EN
      tests++; if (stall_cnt !== CNT_W'(m_stall) || bubble_cnt !== CNT_W'(m_bubble)) begin fails++; bad++; $display("FAIL rnd_cnt cyc %0d got s=%0d b=%0d exp s=%0d b=%0d", i, stall_cnt, bubble_cnt, m_stall, m_bubble); end
`endif
      if (bad > 10) break;
    end
    flush = 1'b0; drive(0, 0, '0); dn.ready = 1'b1;
    cycle(); cycle(); cycle();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; dn.ready = 1'b0; drive(0, 0, '0); cycle();
    rst_n = 1'b1;
    tests++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin fails++; $display("FAIL perf_reset got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt); end
    drive(1, 'h7, 9'h107); cycle();
    drive(0, 0, '0); cycle(); cycle(); cycle();
    tests++; if (stall_cnt !== 2'd3 || bubble_cnt !== 2'd1) begin fails++; $display("FAIL perf_stall got s=%0d b=%0d exp 3 1", stall_cnt, bubble_cnt); end
    cycle();
    tests++; if (stall_cnt !== 2'd3) begin fails++; $display("FAIL perf_sat got s=%0d exp 3", stall_cnt); end
    dn.ready = 1'b1; cycle(); cycle(); cycle(); cycle();
    tests++; if (bubble_cnt !== 2'd3) begin fails++; $display("FAIL perf_bubble got b=%0d exp 3", bubble_cnt); end
    flush = 1'b1; cycle(); flush = 1'b0;
    tests++; if (stall_cnt !== 2'd3 || bubble_cnt !== 2'd3) begin fails++; $display("FAIL perf_flush got s=%0d b=%0d exp 3 3", stall_cnt, bubble_cnt); end
  endtask
`endif

  initial begin
    drive(0, 0, '0);
    dn.ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_fire();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
